spi_slave_tx: RTL and testbench
===============================

# spi_slave_tx

Parametrised SPI slave transmitter: the next generation of the slave's MISO path. It buffers words from the slave's internal logic in a small FIFO and serialises them onto MISO under master control of SCLK/CS. It supports a configurable word width, bit order and SPI mode. SCLK and CS are oversampled in the system clock domain, so the block has a single clock and no SCLK-clocked flops.

## Interface
- DATA_W, 8: bits per SPI word (≥2).
- FIFO_DEPTH, 4: TX FIFO entries (power of two, ≥2).
- LSB_FIRST, 1: 1 = bit 0 shifted first; 0 = MSB first.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = slave drives on trailing edge, first bit valid at CS assertion; 1 = slave drives on leading edge.
- IDLE_WORD, 0: word sent when FIFO is empty at a word boundary.

- clk  in  1  system clock; must be ≥4× SCLK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master, asynchronous to clk.
- CS  in  1  chip select from master, active-high, asynchronous to clk.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  FIFO not full; push occurs when tx_valid & tx_ready.
- MISO  out  1  serial data to master.
- busy  out  1  CS active (synchronised).
- word_done  out  1  one-cycle pulse when the last bit of a word has been launched.
- underrun  out  1  one-cycle pulse when IDLE_WORD is loaded because the FIFO is empty.
- aborted  out  1  one-cycle pulse when CS drops with a word partially shifted.

## Operation
- SCLK and CS each pass through a 2-flop synchroniser plus a history flop. Edges are detected from the last two synchronised samples.
- Launch edge:
  - CPHA=0: trailing edge (falling if CPOL=0, rising if CPOL=1).
  - CPHA=1: leading edge.
- FSM states: IDLE, ARM, SHIFT.
- IDLE:
  - MISO=0, bit counter=0.
  - On a synchronised CS rise: pop the FIFO into the shift register. If the FIFO is empty, load IDLE_WORD and pulse underrun.
  - Then go to ARM.
- ARM (CPHA=0 only; CPHA=1 goes straight to SHIFT):
  - Drive the first bit on MISO in the cycle after the load.
  - Go to SHIFT.
- SHIFT:
  - Each launch edge drives the next bit and increments the counter.
  - When the counter reaches DATA_W (CPHA=1: on the DATA_W-th launch edge; CPHA=0: on the DATA_W-th launch edge, which also serves as the first bit of the next word):
    - pulse word_done;
    - if CS is still active, reload from the FIFO or IDLE_WORD and wrap the counter to 0. Back-to-back words within one CS have no gap.
- Bit order: LSB_FIRST selects shift-right/out bit 0 or shift-left/out bit DATA_W-1.
- CS fall in any state:
  - return to IDLE and drive MISO=0 on the next clk;
  - discard the shift register contents (no FIFO re-push);
  - pulse aborted if 0 < counter < DATA_W.
- CS fall coinciding with the final launch edge counts as word complete: pulse word_done only.
- FIFO: push and pop in the same cycle are both honoured. A push into a full FIFO is impossible (tx_ready=0). A pop from an empty FIFO never occurs; IDLE_WORD substitutes.
- Reset (asynchronous, mid-frame allowed): FIFO emptied, FSM in IDLE. Outputs reset to MISO=0, tx_ready=1, busy=0, word_done=0, underrun=0, aborted=0. The synchronisers reset to CPOL (SCLK) and 0 (CS).

## Timing
- The synchroniser plus edge detection takes 3 clk cycles. MISO updates on the 3rd rising clk edge after an SCLK launch transition at the pin.
- After a CS rise at the pin:
  - busy rises on the 3rd rising clk edge;
  - in CPHA=0, the first bit is on MISO by the 5th clk edge. The master must wait ≥5 clk periods between CS assertion and the first SCLK edge.
- tx_ready falls in the same cycle the push fills the last entry and rises the cycle after a pop from full.
- word_done, underrun and aborted each assert for exactly one clk cycle, registered.

## Structure
- Package spi_pkg:
  - state enum spi_tx_state_t {IDLE, ARM, SHIFT};
  - mode constants SPI_MODE0..3;
  - the synchroniser depth constant SYNC_STAGES=2.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop, full/empty, pointer wrap with an extra MSB.
- Synchronisers, edge detection, FSM and shift register stay in spi_slave_tx.

## Test plan
- Mode 0, LSB_FIRST=1, push 8'hA5, one 8-clock frame → MISO sequence 1,0,1,0,0,1,0,1; one word_done; tx_ready=1 throughout.
- Mode 1, LSB_FIRST=0, push 8'h3C and 8'hC3, 16 SCLKs under one CS → bits 0011110011000011 with no gap; two word_done pulses.
- FIFO empty, IDLE_WORD=8'hFF, CS asserted → underrun pulse; 8 ones shifted.
- Push 5 words into DEPTH=4 → tx_ready=0 after the 4th push; the 5th is held until a pop, after which tx_ready returns to 1 the next cycle.
- CS dropped after 3 bits of 8'h81 → aborted pulse; MISO=0 next cycle; the next frame sends the following FIFO word, not the remainder.
- rst_n asserted mid-word, then released → all outputs at reset values immediately; FIFO empty; next frame underruns.

Source files
------------

// File: rtl/spi_slave_tx_pkg.sv
// Shared types and constants for the SPI slave transmitter.
package spi_pkg;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } spi_tx_state_t;

  // SPI modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Flops in each SCLK/CS synchroniser chain (history flop not included).
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_tx_if.sv
// Word-push interface from the slave's internal logic into the TX FIFO.
//
// Handshake: the master side holds tx_data stable while tx_valid is high;
// a word is transferred on every rising clk edge where tx_valid and
// tx_ready are both high. tx_ready does not depend on tx_valid.
interface spi_slave_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/spi_slave_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Pointers carry an extra MSB so full and empty are told apart on wrap.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Guard against overflow/underflow so the pointers can never cross.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave transmitter: FIFO-buffered words serialised onto MISO.
// SCLK and CS are oversampled in the clk domain; no SCLK-clocked flops.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              FIFO_DEPTH = 4,
  parameter bit              LSB_FIRST  = 1'b1,
  parameter bit              CPOL       = 1'b0,
  parameter bit              CPHA       = 1'b0,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SCLK,
  input  logic          CS,
  spi_slave_tx_if.slave tx_if,
  output logic          MISO,
  output logic          busy,
  output logic          word_done,
  output logic          underrun,
  output logic          aborted,
  output spi_tx_state_t dbg_state
);
  localparam int          CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [1:0]  MODE  = {CPOL, CPHA};
  // Launch on the trailing edge for CPHA=0, leading edge for CPHA=1.
  localparam bit LAUNCH_ON_RISE = (MODE == SPI_MODE1) || (MODE == SPI_MODE2);
  localparam bit LAUNCH_ON_FALL = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);

  // ---------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  logic                   sclk_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, launch;

  // Shift the raw pins through the synchroniser chains.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
    cs_hist_d   = cs_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history registers; SCLK idles at CPOL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      sclk_hist_q <= CPOL;
      cs_sync_q   <= '0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_sync_q   <= cs_sync_d;
      cs_hist_q   <= cs_hist_d;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign launch    = (LAUNCH_ON_RISE & sclk_rise) | (LAUNCH_ON_FALL & sclk_fall);

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic              fifo_full, fifo_empty, push, pop;
  logic [DATA_W-1:0] fifo_rd_data, next_word;

  assign push           = tx_if.tx_valid & ~fifo_full;
  assign tx_if.tx_ready = ~fifo_full;
  // An empty FIFO at a word boundary substitutes the idle word.
  assign next_word      = fifo_empty ? IDLE_WORD : fifo_rd_data;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (tx_if.tx_data),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // FSM and shift register
  // ---------------------------------------------------------------------
  spi_tx_state_t     state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              miso_q, miso_d;
  logic              word_done_q, word_done_d;
  logic              underrun_q, underrun_d;
  logic              aborted_q, aborted_d;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // Next-state, shift and pulse logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    word_done_d = 1'b0;
    underrun_d  = 1'b0;
    aborted_d   = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (cs_rise) begin
          pop        = ~fifo_empty;
          underrun_d = fifo_empty;
          shreg_d    = next_word;
          state_d    = CPHA ? SHIFT : ARM;
        end
      end
      ARM: begin
        if (cs_fall) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          shreg_d = '0;
        end else begin
          // First bit must be valid before the master's first edge.
          miso_d  = first_bit(shreg_q);
          shreg_d = shift_word(shreg_q);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (launch && (cnt_q == LAST_BIT)) begin
          // Word complete; a coincident CS fall is not an abort.
          word_done_d = 1'b1;
          cnt_d       = '0;
          if (cs_fall) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            shreg_d = '0;
          end else begin
            pop        = ~fifo_empty;
            underrun_d = fifo_empty;
            if (CPHA) begin
              // Leading-edge launch: this edge still carries the last bit.
              miso_d  = first_bit(shreg_q);
              shreg_d = next_word;
            end else begin
              // Trailing-edge launch: this edge carries the next word's first bit.
              miso_d  = first_bit(next_word);
              shreg_d = shift_word(next_word);
            end
          end
        end else if (cs_fall) begin
          aborted_d = (cnt_q != '0);
          state_d   = IDLE;
          miso_d    = 1'b0;
          shreg_d   = '0;
          cnt_d     = '0;
        end else if (launch) begin
          miso_d  = first_bit(shreg_q);
          shreg_d = shift_word(shreg_q);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, datapath and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      word_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      word_done_q <= word_done_d;
      underrun_q  <= underrun_d;
      aborted_q   <= aborted_d;
    end
  end

  assign MISO      = miso_q;
  assign busy      = cs_hist_q;
  assign word_done = word_done_q;
  assign underrun  = underrun_q;
  assign aborted   = aborted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench: dut0 is mode 0 / LSB first / idle word FF,
// dut1 is mode 1 / MSB first / idle word 00. Both share SCLK and CS.
module tb_spi_slave_tx;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic sclk, cs;
  always #5 clk = ~clk;

  spi_slave_tx_if #(.DATA_W(8)) if0 ();
  spi_slave_tx_if #(.DATA_W(8)) if1 ();

  logic miso0, busy0, wd0, uf0, ab0;
  logic miso1, busy1, wd1, uf1, ab1;
  spi_tx_state_t st0, st1;

  spi_slave_tx #(
    .DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b1), .CPOL(1'b0), .CPHA(1'b0), .IDLE_WORD(8'hFF)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .CS(cs), .tx_if(if0),
    .MISO(miso0), .busy(busy0), .word_done(wd0), .underrun(uf0), .aborted(ab0), .dbg_state(st0)
  );

  spi_slave_tx #(
    .DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b0), .CPOL(1'b0), .CPHA(1'b1), .IDLE_WORD(8'h00)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .CS(cs), .tx_if(if1),
    .MISO(miso1), .busy(busy1), .word_done(wd1), .underrun(uf1), .aborted(ab1), .dbg_state(st1)
  );

  // ---------------- pulse counters ----------------
  int wd0_cnt = 0, uf0_cnt = 0, ab0_cnt = 0;
  int wd1_cnt = 0, uf1_cnt = 0, ab1_cnt = 0;
  always @(negedge clk) begin
    if (wd0) wd0_cnt++;
    if (uf0) uf0_cnt++;
    if (ab0) ab0_cnt++;
    if (wd1) wd1_cnt++;
    if (uf1) uf1_cnt++;
    if (ab1) ab1_cnt++;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input int which, input logic [7:0] d);
    bit done = 1'b0;
    if (which == 0) begin
      if0.tx_data = d; if0.tx_valid = 1'b1;
    end else begin
      if1.tx_data = d; if1.tx_valid = 1'b1;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if ((which == 0) ? if0.tx_ready : if1.tx_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  // One CS frame of nbits SCLK periods (CPOL=0, 5 clk per half period).
  // dut0 bits sampled before each rising edge into rx0[i] (first bit at [0]);
  // dut1 bits sampled before each falling edge, shifted into rx1 (first bit high).
  task automatic frame(input int nbits,
                       output logic [31:0] rx0, output logic [31:0] rx1,
                       output logic [7:0] rdy_hist, output logic [7:0] busy_hist,
                       output int uf0_setup, output int uf1_setup,
                       output logic rdy_min, output logic miso0_drop);
    int uf0_s, uf1_s;
    rx0 = '0; rx1 = '0; rdy_min = 1'b1;
    @(posedge clk); #1;
    uf0_s = uf0_cnt; uf1_s = uf1_cnt;
    cs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rdy_hist[i]  = if0.tx_ready;
      busy_hist[i] = busy0;
    end
    uf0_setup = uf0_cnt - uf0_s;
    uf1_setup = uf1_cnt - uf1_s;
    for (int i = 0; i < nbits; i++) begin
      rx0[i]  = miso0;
      rdy_min = rdy_min & if0.tx_ready;
      sclk = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rx1  = {rx1[30:0], miso1};
      sclk = 1'b0;
      repeat (5) @(posedge clk);
      #1;
    end
    cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    miso0_drop = miso0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rx0, rx1;
  logic [7:0]  rdy_h, busy_h;
  int          u0s, u1s, wd0_s, wd1_s, ab0_s;
  logic        rdy_min, m0_drop;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs = 1'b0;
    if0.tx_data = '0; if0.tx_valid = 1'b0;
    if1.tx_data = '0; if1.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out0", {31'd0, miso0, if0.tx_ready, busy0, wd0, uf0, ab0}, 32'b010000);
    check("reset_out1", {31'd0, miso1, if1.tx_ready, busy1, wd1, uf1, ab1}, 32'b010000);
    check("reset_state0", 32'(st0), 32'(IDLE));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Mode 0, LSB first, A5.
    push(0, 8'hA5);
    wd0_s = wd0_cnt; ab0_s = ab0_cnt;
    frame(8, rx0, rx1, rdy_h, busy_h, u0s, u1s, rdy_min, m0_drop);
    check("m0_bits", {24'd0, rx0[7:0]}, 32'hA5);
    check("m0_word_done", wd0_cnt - wd0_s, 32'd1);
    check("m0_ready_setup", {24'd0, rdy_h}, 32'hFF);
    check("m0_ready_bits", {31'd0, rdy_min}, 32'd1);
    check("m0_busy_timing", {24'd0, busy_h}, 32'b1111_1100);
    check("m0_no_underrun", u0s, 32'd0);
    check("m0_no_abort", ab0_cnt - ab0_s, 32'd0);
    check("m0_miso_after_cs", {31'd0, m0_drop}, 32'd0);

    // Mode 1, MSB first, two words back to back.
    push(1, 8'h3C);
    push(1, 8'hC3);
    wd1_s = wd1_cnt;
    frame(16, rx0, rx1, rdy_h, busy_h, u0s, u1s, rdy_min, m0_drop);
    check("m1_bits", {16'd0, rx1[15:0]}, 32'h3CC3);
    check("m1_word_done", wd1_cnt - wd1_s, 32'd2);
    check("m1_no_underrun", u1s, 32'd0);

    // Empty FIFO: idle word FF with underrun.
    frame(8, rx0, rx1, rdy_h, busy_h, u0s, u1s, rdy_min, m0_drop);
    check("empty_underrun", u0s, 32'd1);
    check("empty_bits", {24'd0, rx0[7:0]}, 32'hFF);

    // Fill the FIFO, hold a fifth word, then abort after 3 bits.
    push(0, 8'h81);
    push(0, 8'h5A);
    push(0, 8'h11);
    push(0, 8'h22);
    check("full_ready", {31'd0, if0.tx_ready}, 32'd0);
    if0.tx_data = 8'h33; if0.tx_valid = 1'b1;
    ab0_s = ab0_cnt;
    frame(3, rx0, rx1, rdy_h, busy_h, u0s, u1s, rdy_min, m0_drop);
    if0.tx_valid = 1'b0;
    // Pop on the 3rd edge frees a slot for one cycle, then the held word fills it.
    check("pop_ready_pulse", {24'd0, rdy_h}, 32'b0000_0100);
    check("abort_bits", {29'd0, rx0[2:0]}, 32'b001);
    check("abort_pulse", ab0_cnt - ab0_s, 32'd1);
    check("abort_miso", {31'd0, m0_drop}, 32'd0);
    check("abort_no_underrun", u0s, 32'd0);
    frame(8, rx0, rx1, rdy_h, busy_h, u0s, u1s, rdy_min, m0_drop);
    check("after_abort_bits", {24'd0, rx0[7:0]}, 32'h5A);

    // Reset in the middle of a word.
    @(posedge clk); #1;
    cs = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    sclk = 1'b1; repeat (5) @(posedge clk);
    #1;
    sclk = 1'b0; repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_out0", {31'd0, miso0, if0.tx_ready, busy0, wd0, uf0, ab0}, 32'b010000);
    check("midreset_state0", 32'(st0), 32'(IDLE));
    cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    frame(8, rx0, rx1, rdy_h, busy_h, u0s, u1s, rdy_min, m0_drop);
    check("postreset_underrun", u0s, 32'd1);
    check("postreset_bits", {24'd0, rx0[7:0]}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
